seq_booth_mult: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier. It retires one Booth digit per clock, so it trades latency for area against the fully combinational 8-bit multiplier. A start/busy/done handshake lets a controller or datapath sequencer issue operands and collect a registered 2*WIDTH product. Sits between operand registers and the result bus of the arithmetic unit.

---
 rtl/seq_booth_mult.sv | 103 ++++++++++
 tb/tb_seq_booth_mult.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mult.sv
// seq_booth_mult: iterative radix-4 Booth multiplier, one digit per clock.
// start/busy/done handshake; registered 2*WIDTH product on p.
// Optional macro BOOTH_UNSIGNED_EN adds is_signed (unsigned mode uses N+1 digits).
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               is_signed,
`endif
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int N  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("seq_booth_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   mcand;  // multiplicand, pre-shifted by 2k for the current digit
  logic [WIDTH+2:0] yr;    // {ext, y, y[-1]}; low 3 bits are the current digit
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   last;   // index of the final digit for this operation
  logic [PW-1:0]   pp;
  logic            sgn;

`ifdef BOOTH_UNSIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b1;
`endif

  // Booth recoding of the current digit into a 2*WIDTH partial product
  always_comb begin
    pp = '0;
    case (yr[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = {mcand[PW-2:0], 1'b0};
      3'b100:         pp = -{mcand[PW-2:0], 1'b0};
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // Control FSM and datapath; outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      yr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      last  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Unsigned mode zero-extends both operands; the 2 extra y bits
            // give one more digit so the top operand bit is not read as sign.
            mcand <= sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
            yr    <= {(sgn ? {2{y[WIDTH-1]}} : 2'b00), y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            last  <= sgn ? CW'(N - 1) : CW'(N);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc + pp;
          mcand <= {mcand[PW-3:0], 2'b00};
          yr    <= {2'b00, yr[WIDTH+2:2]};
          cnt   <= cnt + 1'b1;
          if (cnt == last) state <= DONE;
        end
        DONE: begin
          p     <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Self-checking bench for seq_booth_mult (WIDTH=8) against an arithmetic model.
module tb_seq_booth_mult;
  localparam int W = 8;
  localparam int N = W / 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   x, y;
  logic           busy, done;
  logic [2*W-1:0] p;
  logic [2*W-1:0] prev_p;

  int total = 0;
  int bad   = 0;

  seq_booth_mult #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed(is_signed),
`endif
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .p        (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg);
    longint pa, pb;
    pa = sg ? longint'($signed(a)) : longint'({1'b0, a});
    pb = sg ? longint'($signed(b)) : longint'({1'b0, b});
    return (2*W)'(pa * pb);
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  // hold=1 keeps start high and scrambles operands while busy.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sg, input bit hold);
    int lat;
    int exp_lat;
    logic [2*W-1:0] exp_p;
`ifdef BOOTH_UNSIGNED_EN
    exp_lat = sg ? N + 1 : N + 2;
`else
    sg = 1'b1;
    exp_lat = N + 1;
`endif
    exp_p = model(a, b, sg);
    start = 1'b1; x = a; y = b; is_signed = sg;
    @(negedge clk);
    lat = 0;
    start = hold;
    if (hold) begin x = W'($urandom); y = W'($urandom); is_signed = 1'($urandom); end
    while (!done && lat < 30) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_phold"}, 32'(p), 32'(prev_p));
      @(negedge clk);
      lat++;
      if (hold) begin x = W'($urandom); y = W'($urandom); is_signed = 1'($urandom); end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_p"}, 32'(p), 32'(exp_p));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    prev_p = exp_p;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b1; x = '0; y = '0; prev_p = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners, issued back to back at the minimum interval
    op("m128sq", 8'h80, 8'h80, 1'b1, 1'b0);
    op("maxneg", 8'h7F, 8'h80, 1'b1, 1'b0);
    op("neg1",   8'hFF, 8'h01, 1'b1, 1'b0);
    op("zero",   8'h00, 8'h5A, 1'b1, 1'b0);
    op("b2b_a",  8'd3,  8'hFB, 1'b1, 1'b0);
    op("b2b_b",  8'hF9, 8'hF9, 1'b1, 1'b0);
    chk("b2b_b_val", 32'(p), 32'h0031);

    // Idle: p holds, no stray done
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_p", 32'(p), 32'(prev_p));
    end

    // Start held high with operands changing every cycle
    for (int i = 0; i < 4; i++)
      op("hold", W'($urandom), W'($urandom), 1'b1, 1'b1);
    start = 1'b0;
    @(negedge clk);
    chk("hold_after_busy", 32'(busy), 32'd0);

    // Reset in the middle of CALC aborts with no done
    start = 1'b1; x = 8'd9; y = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_p", 32'(p), 32'd0);
    prev_p = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
    end
    op("after_rst", 8'd5, 8'd6, 1'b1, 1'b0);
    chk("after_rst_30", 32'(p), 32'd30);

    // Random signed operands
    for (int i = 0; i < 20; i++)
      op("rnd_s", W'($urandom), W'($urandom), 1'b1, 1'b0);

`ifdef BOOTH_UNSIGNED_EN
    op("u_ffff", 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("u_ffff_val", 32'(p), 32'hFE01);
    op("s_ffff", 8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("s_ffff_val", 32'(p), 32'h0001);
    for (int i = 0; i < 20; i++)
      op("rnd_m", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif

    start = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
